n_term_capture: RTL and testbench

N_TERM_CAPTURE -- requirements
Module: n_term_capture

---
 rtl/n_term_capture_pkg.sv | 22 ++
 rtl/n_term_serializer.sv | 71 +++++++
 rtl/n_term_capture.sv | 120 ++++++++++++
 tb/tb_n_term_capture.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/n_term_capture_pkg.sv
// Shared definitions for the north-edge termination/capture tile.
//   - per-bundle wire widths of the north-arriving wires
//   - snapshot width, statistics counter width, serializer bit-counter width
//   - serializer FSM state enumeration
package n_term_capture_pkg;

   localparam int unsigned N1_W = 4;
   localparam int unsigned N2_W = 8;
   localparam int unsigned N4_W = 16;
   localparam int unsigned CI_W = 1;

   // {Ci, N4END, N2END, N2MID, N1END}
   localparam int unsigned SNAP_W    = 37;
   localparam int unsigned CNT_W     = 8;
   localparam int unsigned BIT_CNT_W = $clog2(SNAP_W);

   typedef enum logic {
      StIdle,
      StShift
   } ser_state_e;

endpackage

// File: rtl/n_term_serializer.sv
// Snapshot serializer: loads a SNAP_W-bit snapshot and shifts it out LSB first over a
// valid/ready handshake.
//   clk_i, rst_i     clock, asynchronous active-high reset
//   start_i          capture request; only honoured while idle
//   snap_i           snapshot loaded on the start edge
//   ser_ready_i      consumer accepts the current bit
//   busy_o           transfer in progress
//   ser_valid_o      ser_data_o valid
//   ser_data_o       current bit (0 while idle)
//   ser_last_o       current bit is the final one
//   done_o           final handshake happens at the coming edge
module n_term_serializer
   import n_term_capture_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic [SNAP_W-1:0] snap_i,
   input  logic              ser_ready_i,
   output logic              busy_o,
   output logic              ser_valid_o,
   output logic              ser_data_o,
   output logic              ser_last_o,
   output logic              done_o
);

   localparam logic [BIT_CNT_W-1:0] LastBit = BIT_CNT_W'(SNAP_W - 1);

   ser_state_e            state_q;
   logic [SNAP_W-1:0]     shadow_q;
   logic [BIT_CNT_W-1:0]  bit_cnt_q;
   logic                  shifting;
   logic                  last;

   assign shifting    = (state_q == StShift);
   assign last        = shifting && (bit_cnt_q == LastBit);
   assign busy_o      = shifting;
   assign ser_valid_o = shifting;
   assign ser_data_o  = shifting & shadow_q[0];
   assign ser_last_o  = last;
   assign done_o      = last && ser_ready_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= StIdle;
         shadow_q  <= '0;
         bit_cnt_q <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start_i) begin
                  shadow_q  <= snap_i;
                  bit_cnt_q <= '0;
                  state_q   <= StShift;
               end
            end
            StShift: begin
               if (ser_ready_i) begin
                  shadow_q  <= shadow_q >> 1;
                  bit_cnt_q <= bit_cnt_q + BIT_CNT_W'(1);
                  if (last) begin
                     state_q <= StIdle;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: rtl/n_term_capture.sv
// North-edge termination tile: loops the north-arriving wires back south and offers a
// serial snapshot of all incoming wires plus capture/drop statistics.
//   UserCLK, Reset         clock, asynchronous active-high reset
//   N1END/N2MID/N2END/N4END, Ci   incoming wires (Ci is only ever captured)
//   S1BEG/S2BEG/S2BEGb/S4BEG      loopback, combinational or 1-cycle registered (LOOP_REG)
//   cap_req, cap_busy             snapshot request / transfer in progress
//   ser_data/ser_valid/ser_ready/ser_last   serial snapshot stream, LSB first
//   cap_cnt                completed captures, wrapping
//   drop_cnt               cap_req cycles ignored while busy, saturating
module n_term_capture
   import n_term_capture_pkg::*;
#(
   parameter int unsigned MaxFramesPerCol = 20,
   parameter int unsigned FrameBitsPerRow = 32,
   parameter int unsigned NoConfigBits    = 0,
   parameter int unsigned LOOP_REG        = 0
) (
   input  logic             UserCLK,
   input  logic             Reset,
   input  logic [N1_W-1:0]  N1END,
   input  logic [N2_W-1:0]  N2MID,
   input  logic [N2_W-1:0]  N2END,
   input  logic [N4_W-1:0]  N4END,
   input  logic [CI_W-1:0]  Ci,
   output logic [N1_W-1:0]  S1BEG,
   output logic [N2_W-1:0]  S2BEG,
   output logic [N2_W-1:0]  S2BEGb,
   output logic [N4_W-1:0]  S4BEG,
   input  logic             cap_req,
   output logic             cap_busy,
   output logic             ser_data,
   output logic             ser_valid,
   input  logic             ser_ready,
   output logic             ser_last,
   output logic [CNT_W-1:0] cap_cnt,
   output logic [CNT_W-1:0] drop_cnt
);

   // Frame geometry is carried for fabric compatibility only; reject nonsense values.
   if (LOOP_REG > 1 || NoConfigBits != 0 || MaxFramesPerCol * FrameBitsPerRow == 0) begin : g_bad
      $error("n_term_capture: unsupported parameter combination");
   end

   if (LOOP_REG != 0) begin : g_loop_reg
      logic [N1_W-1:0] s1_q;
      logic [N2_W-1:0] s2_q;
      logic [N2_W-1:0] s2b_q;
      logic [N4_W-1:0] s4_q;

      always_ff @(posedge UserCLK or posedge Reset) begin
         if (Reset) begin
            s1_q  <= '0;
            s2_q  <= '0;
            s2b_q <= '0;
            s4_q  <= '0;
         end else begin
            s1_q  <= N1END;
            s2_q  <= N2MID;
            s2b_q <= N2END;
            s4_q  <= N4END;
         end
      end

      assign S1BEG  = s1_q;
      assign S2BEG  = s2_q;
      assign S2BEGb = s2b_q;
      assign S4BEG  = s4_q;
   end else begin : g_loop_comb
      assign S1BEG  = N1END;
      assign S2BEG  = N2MID;
      assign S2BEGb = N2END;
      assign S4BEG  = N4END;
   end

   logic [SNAP_W-1:0] snap;
   logic              done;
   logic [CNT_W-1:0]  cap_cnt_q, cap_cnt_d;
   logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

   assign snap = {Ci, N4END, N2END, N2MID, N1END};

   n_term_serializer u_ser (
      .clk_i       (UserCLK),
      .rst_i       (Reset),
      .start_i     (cap_req),
      .snap_i      (snap),
      .ser_ready_i (ser_ready),
      .busy_o      (cap_busy),
      .ser_valid_o (ser_valid),
      .ser_data_o  (ser_data),
      .ser_last_o  (ser_last),
      .done_o      (done)
   );

   // A request on the final-handshake edge still sees the serializer busy, so it is a drop.
   always_comb begin
      cap_cnt_d  = cap_cnt_q;
      drop_cnt_d = drop_cnt_q;
      if (done) begin
         cap_cnt_d = cap_cnt_q + CNT_W'(1);
      end
      if (cap_req && cap_busy && (drop_cnt_q != {CNT_W{1'b1}})) begin
         drop_cnt_d = drop_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge UserCLK or posedge Reset) begin
      if (Reset) begin
         cap_cnt_q  <= '0;
         drop_cnt_q <= '0;
      end else begin
         cap_cnt_q  <= cap_cnt_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign cap_cnt  = cap_cnt_q;
   assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_n_term_capture.sv
module tb_n_term_capture;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  n1;
   logic [7:0]  n2m, n2e;
   logic [15:0] n4;
   logic        ci;
   logic        cap_req, ser_ready;

   logic [3:0]  s1, r_s1;
   logic [7:0]  s2, s2b, r_s2, r_s2b;
   logic [15:0] s4, r_s4;
   logic        cap_busy, ser_data, ser_valid, ser_last;
   logic        r_cap_busy, r_ser_data, r_ser_valid, r_ser_last;
   logic [7:0]  cap_cnt, drop_cnt, r_cap_cnt, r_drop_cnt;

   int checks = 0;
   int errors = 0;
   int exp_cap = 0;
   int exp_drop = 0;

   always #5 clk = ~clk;

   n_term_capture #(.LOOP_REG(0)) dut (
      .UserCLK(clk), .Reset(rst), .N1END(n1), .N2MID(n2m), .N2END(n2e), .N4END(n4), .Ci(ci),
      .S1BEG(s1), .S2BEG(s2), .S2BEGb(s2b), .S4BEG(s4), .cap_req(cap_req), .cap_busy(cap_busy),
      .ser_data(ser_data), .ser_valid(ser_valid), .ser_ready(ser_ready), .ser_last(ser_last),
      .cap_cnt(cap_cnt), .drop_cnt(drop_cnt)
   );

   n_term_capture #(.LOOP_REG(1)) dut_r (
      .UserCLK(clk), .Reset(rst), .N1END(n1), .N2MID(n2m), .N2END(n2e), .N4END(n4), .Ci(ci),
      .S1BEG(r_s1), .S2BEG(r_s2), .S2BEGb(r_s2b), .S4BEG(r_s4), .cap_req(cap_req),
      .cap_busy(r_cap_busy), .ser_data(r_ser_data), .ser_valid(r_ser_valid),
      .ser_ready(ser_ready), .ser_last(r_ser_last), .cap_cnt(r_cap_cnt), .drop_cnt(r_drop_cnt)
   );

   // Reference snapshot: the incoming wires in capture order, N1END[0] first.
   function automatic logic [36:0] snap_model();
      return {ci, n4, n2e, n2m, n1};
   endfunction

   task automatic rand_inputs();
      n1  = 4'($urandom);
      n2m = 8'($urandom);
      n2e = 8'($urandom);
      n4  = 16'($urandom);
      ci  = 1'($urandom);
   endtask

   task automatic reset_dut();
      @(negedge clk);
      rst = 1'b1; cap_req = 1'b0; ser_ready = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      exp_cap = 0; exp_drop = 0;
   endtask

   // Called at a negedge with the DUT idle. Issues a capture and consumes the stream.
   // mode 0: always ready, 1: ready toggles 1/0, 2: random ready.
   task automatic run_transfer(input int mode, input bit hold_req, output logic [36:0] bits,
                               output int cycles, output int last_err, output int stable_err,
                               output int valid_err);
      int idx;
      bit prev_stall;
      logic prev_data;
      bit rdy;
      bits = '0; cycles = 0; last_err = 0; stable_err = 0; valid_err = 0;
      idx = 0; prev_stall = 0; prev_data = 1'b0;
      cap_req = 1'b1;
      ser_ready = 1'b0;
      @(negedge clk);
      if (!hold_req) cap_req = 1'b0;
      while (idx < 37 && cycles < 400) begin
         if (ser_valid !== 1'b1 || cap_busy !== 1'b1) begin
            valid_err++;
            break;
         end
         if (ser_last !== (idx == 36)) last_err++;
         if (prev_stall && ser_data !== prev_data) stable_err++;
         case (mode)
            0: rdy = 1'b1;
            1: rdy = (cycles % 2 == 0);
            default: rdy = 1'($urandom_range(0, 1));
         endcase
         ser_ready = rdy;
         if (rdy) begin
            bits[idx] = ser_data;
            idx++;
         end
         prev_stall = !rdy;
         prev_data = ser_data;
         cycles++;
         @(negedge clk);
      end
      if (idx < 37) valid_err++;
      cap_req = 1'b0;
      ser_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; cap_req = 1'b1; ser_ready = 1'b1;
      n1 = 4'hF; n2m = 8'hFF; n2e = 8'hFF; n4 = 16'hA5C3; ci = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if ({ser_valid, cap_busy, ser_data, ser_last} !== 4'b0) begin
         errors++; $display("FAIL reset_outs: got %b want 0000", {ser_valid, cap_busy, ser_data, ser_last});
      end
      checks++; if (cap_cnt !== 8'd0) begin errors++; $display("FAIL reset_cap_cnt: got %0d want 0", cap_cnt); end
      checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_drop_cnt: got %0d want 0", drop_cnt); end
      checks++; if (r_s4 !== 16'h0) begin errors++; $display("FAIL reset_loopreg_s4: got %h want 0000", r_s4); end
      checks++; if (s4 !== 16'hA5C3) begin errors++; $display("FAIL reset_comb_s4: got %h want a5c3", s4); end
      rst = 1'b0; cap_req = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (ser_valid !== 1'b0 || cap_cnt !== 8'd0) begin
         errors++; $display("FAIL reset_no_stale_req: valid %b cap_cnt %0d want 0/0", ser_valid, cap_cnt);
      end
      ser_ready = 1'b0;
   endtask

   task automatic test_loopback();
      logic [35:0] prev;
      @(negedge clk);
      n4 = 16'h0000;
      @(negedge clk);
      prev = {n4, n2e, n2m, n1};
      n4 = 16'hA5C3;
      #1;
      checks++; if (s4 !== 16'hA5C3) begin errors++; $display("FAIL loop_comb_a5c3: got %h want a5c3", s4); end
      checks++; if (r_s4 !== prev[35:20]) begin errors++; $display("FAIL loop_reg_early: got %h want %h", r_s4, prev[35:20]); end
      @(negedge clk);
      checks++; if (r_s4 !== 16'hA5C3) begin errors++; $display("FAIL loop_reg_a5c3: got %h want a5c3", r_s4); end
      for (int i = 0; i < 8; i++) begin
         prev = {n4, n2e, n2m, n1};
         rand_inputs();
         #1;
         checks++; if ({s4, s2b, s2, s1} !== {n4, n2e, n2m, n1}) begin
            errors++; $display("FAIL loop_comb_rand: got %h want %h", {s4, s2b, s2, s1}, {n4, n2e, n2m, n1});
         end
         checks++; if ({r_s4, r_s2b, r_s2, r_s1} !== prev) begin
            errors++; $display("FAIL loop_reg_rand: got %h want %h", {r_s4, r_s2b, r_s2, r_s1}, prev);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_capture();
      logic [36:0] bits;
      int cyc, le, se, ve;
      @(negedge clk);
      n1 = 4'h9; n2m = 8'h3C; n2e = 8'hF0; n4 = 16'h1234; ci = 1'b1;
      checks++; if (snap_model() !== 37'h1_1234_F03C9) begin
         errors++; $display("FAIL snap_order: got %h want 1_1234_f03c9", snap_model());
      end
      run_transfer(0, 1'b0, bits, cyc, le, se, ve);
      exp_cap = (exp_cap + 1) % 256;
      checks++; if (bits !== 37'h1_1234_F03C9) begin errors++; $display("FAIL cap_bits: got %h want 1_1234_f03c9", bits); end
      checks++; if (le !== 0 || ve !== 0) begin errors++; $display("FAIL cap_last_valid: got %0d/%0d want 0/0", le, ve); end
      checks++; if (cyc !== 37) begin errors++; $display("FAIL cap_cycles: got %0d want 37", cyc); end
      checks++; if (cap_cnt !== 8'(exp_cap)) begin errors++; $display("FAIL cap_cnt: got %0d want %0d", cap_cnt, exp_cap); end
      checks++; if ({ser_valid, ser_data, ser_last, cap_busy} !== 4'b0) begin
         errors++; $display("FAIL cap_idle_after: got %b want 0000", {ser_valid, ser_data, ser_last, cap_busy});
      end
      for (int i = 0; i < 4; i++) begin
         logic [36:0] exp;
         rand_inputs();
         exp = snap_model();
         run_transfer(i % 2 == 0 ? 2 : 0, 1'b0, bits, cyc, le, se, ve);
         exp_cap = (exp_cap + 1) % 256;
         checks++; if (bits !== exp || le !== 0 || se !== 0 || ve !== 0) begin
            errors++; $display("FAIL cap_rand: got %h want %h (last %0d stable %0d valid %0d)", bits, exp, le, se, ve);
         end
      end
      checks++; if (cap_cnt !== 8'(exp_cap) || drop_cnt !== 8'(exp_drop)) begin
         errors++; $display("FAIL cap_counts: got %0d/%0d want %0d/%0d", cap_cnt, drop_cnt, exp_cap, exp_drop);
      end
   endtask

   task automatic test_backpressure();
      logic [36:0] bits;
      int cyc, le, se, ve;
      n1 = 4'h9; n2m = 8'h3C; n2e = 8'hF0; n4 = 16'h1234; ci = 1'b1;
      run_transfer(1, 1'b0, bits, cyc, le, se, ve);
      exp_cap = (exp_cap + 1) % 256;
      checks++; if (bits !== 37'h1_1234_F03C9) begin errors++; $display("FAIL bp_bits: got %h want 1_1234_f03c9", bits); end
      checks++; if (cyc !== 73) begin errors++; $display("FAIL bp_cycles: got %0d want 73", cyc); end
      checks++; if (se !== 0 || le !== 0 || ve !== 0) begin
         errors++; $display("FAIL bp_hold: stable %0d last %0d valid %0d want 0/0/0", se, le, ve);
      end
   endtask

   task automatic test_drops();
      logic [36:0] bits, exp;
      int cyc, le, se, ve;
      reset_dut();
      rand_inputs();
      exp = snap_model();
      run_transfer(0, 1'b1, bits, cyc, le, se, ve);
      exp_cap = (exp_cap + 1) % 256;
      exp_drop = (exp_drop + cyc > 255) ? 255 : exp_drop + cyc;
      checks++; if (bits !== exp) begin errors++; $display("FAIL drop_hold_bits: got %h want %h", bits, exp); end
      checks++; if (drop_cnt !== 8'd37) begin errors++; $display("FAIL drop_cnt_37: got %0d want 37", drop_cnt); end
      checks++; if (cap_cnt !== 8'd1) begin errors++; $display("FAIL drop_cap_cnt: got %0d want 1", cap_cnt); end
      // Long stall with the request held: counter saturates, shadow untouched.
      rand_inputs();
      exp = snap_model();
      cap_req = 1'b1; ser_ready = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 300; i++) begin
         if (i == 50) rand_inputs();
         @(negedge clk);
         exp_drop = (exp_drop + 1 > 255) ? 255 : exp_drop + 1;
         if (i == 99) begin
            checks++; if (drop_cnt !== 8'(exp_drop)) begin errors++; $display("FAIL drop_mid: got %0d want %0d", drop_cnt, exp_drop); end
         end
      end
      checks++; if (drop_cnt !== 8'd255) begin errors++; $display("FAIL drop_sat: got %0d want 255", drop_cnt); end
      cap_req = 1'b0; ser_ready = 1'b1;
      for (int b = 0; b < 37; b++) begin
         bits[b] = ser_data;
         @(negedge clk);
      end
      ser_ready = 1'b0;
      exp_cap = (exp_cap + 1) % 256;
      checks++; if (bits !== exp) begin errors++; $display("FAIL drop_shadow_kept: got %h want %h", bits, exp); end
      checks++; if (cap_cnt !== 8'(exp_cap) || ser_valid !== 1'b0) begin
         errors++; $display("FAIL drop_end: cap_cnt %0d valid %b want %0d/0", cap_cnt, ser_valid, exp_cap);
      end
   endtask

   task automatic test_abort();
      logic [36:0] bits, exp;
      int cyc, le, se, ve;
      reset_dut();
      rand_inputs();
      exp = snap_model();
      cap_req = 1'b1; ser_ready = 1'b1;
      @(negedge clk);
      cap_req = 1'b0;
      repeat (10) @(negedge clk);
      checks++; if (ser_valid !== 1'b1 || ser_data !== exp[10]) begin
         errors++; $display("FAIL abort_pre: valid %b data %b want 1/%b", ser_valid, ser_data, exp[10]);
      end
      rst = 1'b1;
      #1;
      checks++; if (ser_valid !== 1'b0 || cap_busy !== 1'b0) begin
         errors++; $display("FAIL abort_async: valid %b busy %b want 0/0", ser_valid, cap_busy);
      end
      checks++; if (cap_cnt !== 8'd0) begin errors++; $display("FAIL abort_cap_cnt: got %0d want 0", cap_cnt); end
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (ser_valid !== 1'b0) begin errors++; $display("FAIL abort_stay_idle: got %b want 0", ser_valid); end
      ser_ready = 1'b0;
      rand_inputs();
      exp = snap_model();
      run_transfer(0, 1'b0, bits, cyc, le, se, ve);
      checks++; if (bits !== exp || cap_cnt !== 8'd1) begin
         errors++; $display("FAIL abort_restart: got %h cnt %0d want %h cnt 1", bits, cap_cnt, exp);
      end
      exp_cap = 1;
   endtask

   task automatic test_wrap();
      logic [36:0] bits, exp;
      int cyc, le, se, ve, bad;
      bad = 0;
      reset_dut();
      for (int i = 0; i < 256; i++) begin
         rand_inputs();
         exp = snap_model();
         run_transfer(0, 1'b0, bits, cyc, le, se, ve);
         exp_cap = (exp_cap + 1) % 256;
         if (bits !== exp || le !== 0 || ve !== 0) bad++;
         if (i == 254) begin
            checks++; if (cap_cnt !== 8'd255) begin errors++; $display("FAIL wrap_255: got %0d want 255", cap_cnt); end
         end
      end
      checks++; if (cap_cnt !== 8'd0) begin errors++; $display("FAIL wrap_0: got %0d want 0", cap_cnt); end
      checks++; if (bad !== 0) begin errors++; $display("FAIL wrap_bits: got %0d bad transfers want 0", bad); end
   endtask

   initial begin
      test_reset();
      test_loopback();
      test_capture();
      test_backpressure();
      test_drops();
      test_abort();
      test_wrap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
